// File: rtl/otter_mem_arbiter.sv
// Shared OTTER memory port arbiter: MEM-stage data access (DM) has priority over instruction fetch (IF).
// Optional macro ARB_FAIRNESS_EN lets a starved fetch win one cycle after STARVE_LIMIT denials.
module otter_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic              IF_GNT,
    output logic              IF_VALID,
    output logic [DATA_W-1:0] IF_DATA,
    input  logic              DM_REQ,
    input  logic              DM_WE,
    input  logic [ADDR_W-1:0] DM_ADDR,
    input  logic [DATA_W-1:0] DM_WDATA,
    input  logic [1:0]        DM_SIZE,
    input  logic              DM_SIGN,
    output logic              DM_GNT,
    output logic              DM_VALID,
    output logic [DATA_W-1:0] DM_RDATA,
    output logic              MEM_RD,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              STALL_IF
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_DM   = 2'd2
    } rsp_t;

    rsp_t              rsp_q, rsp_d;
    logic              dm_load_q;
    logic [DATA_W-1:0] if_data_q;
    logic [DATA_W-1:0] dm_data_q;
    logic              force_if;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
            $error("otter_mem_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

`ifdef ARB_FAIRNESS_EN
    logic [3:0] starve_q;

    assign force_if = IF_REQ && (starve_q == 4'(STARVE_LIMIT));

    // Counts consecutive denied fetch cycles; the forced IF win itself clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            starve_q <= 4'd0;
        end else if (IF_REQ && !IF_GNT) begin
            starve_q <= starve_q + 4'd1;
        end else begin
            starve_q <= 4'd0;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        DM_GNT    = DM_REQ & ~force_if;
        IF_GNT    = IF_REQ & ~DM_GNT;
        STALL_IF  = IF_REQ & ~IF_GNT;
        MEM_RD    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_SIZE  = 2'b00;
        MEM_SIGN  = 1'b0;
        rsp_d     = RSP_NONE;
        if (DM_GNT) begin
            MEM_RD    = ~DM_WE;
            MEM_WE    = DM_WE;
            MEM_ADDR  = DM_ADDR;
            MEM_WDATA = DM_WDATA;
            MEM_SIZE  = DM_SIZE;
            MEM_SIGN  = DM_SIGN;
            rsp_d     = RSP_DM;
        end else if (IF_GNT) begin
            MEM_RD    = 1'b1;
            MEM_ADDR  = IF_ADDR;
            MEM_SIZE  = 2'b10;
            rsp_d     = RSP_IF;
        end
    end

    // Stores acknowledge through DM_VALID but must not disturb the held load result.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_q     <= RSP_NONE;
            dm_load_q <= 1'b0;
            if_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            rsp_q     <= rsp_d;
            dm_load_q <= DM_GNT & ~DM_WE;
            if (rsp_q == RSP_IF) begin
                if_data_q <= MEM_RDATA;
            end
            if (rsp_q == RSP_DM && dm_load_q) begin
                dm_data_q <= MEM_RDATA;
            end
        end
    end

    assign IF_VALID = (rsp_q == RSP_IF);
    assign DM_VALID = (rsp_q == RSP_DM);
    assign IF_DATA  = IF_VALID ? MEM_RDATA : if_data_q;
    assign DM_RDATA = (DM_VALID && dm_load_q) ? MEM_RDATA : dm_data_q;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: a driver predicts grants and queues expected responses,
// a monitor pops them against the VALID/data outputs. Honours ARB_FAIRNESS_EN when defined.
module tb_otter_mem_arbiter;

    localparam int StarveLimit = 4;
`ifdef ARB_FAIRNESS_EN
    localparam bit Fair = 1'b1;
`else
    localparam bit Fair = 1'b0;
`endif

    logic        CLK;
    logic        RESET;
    logic        IF_REQ;
    logic [31:0] IF_ADDR;
    logic        IF_GNT;
    logic        IF_VALID;
    logic [31:0] IF_DATA;
    logic        DM_REQ;
    logic        DM_WE;
    logic [31:0] DM_ADDR;
    logic [31:0] DM_WDATA;
    logic [1:0]  DM_SIZE;
    logic        DM_SIGN;
    logic        DM_GNT;
    logic        DM_VALID;
    logic [31:0] DM_RDATA;
    logic        MEM_RD;
    logic        MEM_WE;
    logic [31:0] MEM_ADDR;
    logic [31:0] MEM_WDATA;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_RDATA;
    logic        STALL_IF;

    otter_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(StarveLimit)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_GNT(IF_GNT),
        .IF_VALID(IF_VALID), .IF_DATA(IF_DATA),
        .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_ADDR(DM_ADDR), .DM_WDATA(DM_WDATA),
        .DM_SIZE(DM_SIZE), .DM_SIGN(DM_SIGN), .DM_GNT(DM_GNT),
        .DM_VALID(DM_VALID), .DM_RDATA(DM_RDATA),
        .MEM_RD(MEM_RD), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_RDATA(MEM_RDATA),
        .STALL_IF(STALL_IF)
    );

    // owner: 0 = nobody, 1 = fetch, 2 = data port
    typedef struct {
        int          due;
        int          owner;
        bit          load;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          starve = 0;
    logic [31:0] rdata_pending = 32'h0;
    logic [31:0] if_hold = 32'h0;
    logic [31:0] dm_hold = 32'h0;
    bit          last_if_gnt;
    bit          last_dm_gnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic compare(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic checkOutput(input bit eif, input bit edm, input bit ifr, input logic [31:0] ia,
                               input bit we, input logic [31:0] da, input logic [31:0] wd,
                               input logic [1:0] sz, input bit sg);
        compare("if_gnt", IF_GNT, eif);
        compare("dm_gnt", DM_GNT, edm);
        compare("stall_if", STALL_IF, ifr && !eif);
        compare("mem_rd", MEM_RD, (edm && !we) || eif);
        compare("mem_we", MEM_WE, edm && we);
        compare("mem_addr", MEM_ADDR, edm ? da : (eif ? ia : 32'h0));
        compare("mem_wdata", MEM_WDATA, edm ? wd : 32'h0);
        compare("mem_size", MEM_SIZE, edm ? sz : (eif ? 2'b10 : 2'b00));
        compare("mem_sign", MEM_SIGN, edm ? sg : 1'b0);
    endtask

    // One bus cycle: drive requests, check the issue side, queue what must come back next cycle.
    task automatic applyStimulus(input bit ifr, input logic [31:0] ia, input bit dmr, input bit we,
                                 input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz,
                                 input bit sg, input logic [31:0] rnext);
        bit   force_if;
        bit   eif;
        bit   edm;
        exp_t e;
        @(posedge CLK);
        #1;
        IF_REQ    = ifr;
        IF_ADDR   = ia;
        DM_REQ    = dmr;
        DM_WE     = we;
        DM_ADDR   = da;
        DM_WDATA  = wd;
        DM_SIZE   = sz;
        DM_SIGN   = sg;
        MEM_RDATA = rdata_pending;
        #1;
        force_if = Fair && ifr && (starve == StarveLimit);
        edm = dmr && !force_if;
        eif = ifr && !edm;
        checkOutput(eif, edm, ifr, ia, we, da, wd, sz, sg);
        if (eif || edm) begin
            e.due   = cyc + 1;
            e.owner = eif ? 1 : 2;
            e.load  = edm && !we;
            e.rdata = rnext;
            sb.push_back(e);
        end
        starve = (ifr && !eif) ? starve + 1 : 0;
        rdata_pending = rnext;
        last_if_gnt = eif;
        last_dm_gnt = edm;
    endtask

    task automatic idle(input logic [31:0] rnext);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, rnext);
    endtask

    // Monitor: every mid-cycle, pop the response due now (if any) and check both return ports.
    always @(negedge CLK) begin
        if (RESET) begin
            sb.delete();
            if_hold = 32'h0;
            dm_hold = 32'h0;
            compare("rst_if_valid", IF_VALID, 1'b0);
            compare("rst_dm_valid", DM_VALID, 1'b0);
            compare("rst_if_data", IF_DATA, 32'h0);
            compare("rst_dm_rdata", DM_RDATA, 32'h0);
        end else begin
            mon_e.owner = 0;
            mon_e.load  = 1'b0;
            mon_e.rdata = 32'h0;
            mon_e.due   = cyc;
            while (sb.size() > 0 && sb[0].due < cyc) begin
                compare("stale_response", 64'(sb[0].due), 64'(cyc));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) mon_e = sb.pop_front();
            compare("if_valid", IF_VALID, mon_e.owner == 1);
            compare("dm_valid", DM_VALID, mon_e.owner == 2);
            compare("if_data", IF_DATA, (mon_e.owner == 1) ? mon_e.rdata : if_hold);
            if (!(mon_e.owner == 2 && !mon_e.load))
                compare("dm_rdata", DM_RDATA, (mon_e.owner == 2) ? mon_e.rdata : dm_hold);
            if (mon_e.owner == 1) if_hold = mon_e.rdata;
            if (mon_e.owner == 2 && mon_e.load) dm_hold = mon_e.rdata;
        end
    end

    initial begin
        bit          rif;
        bit          rdm;
        bit          rwe;
        bit          rsg;
        logic [31:0] ria;
        logic [31:0] rda;
        logic [31:0] rwd;
        logic [1:0]  rsz;

        RESET = 1'b1;
        IF_REQ = 1'b0; IF_ADDR = 32'h0;
        DM_REQ = 1'b0; DM_WE = 1'b0; DM_ADDR = 32'h0; DM_WDATA = 32'h0;
        DM_SIZE = 2'b00; DM_SIGN = 1'b0; MEM_RDATA = 32'h0;
        repeat (2) @(posedge CLK);
        #3 RESET = 1'b0;

        $display("[TB] directed: single fetch");
        applyStimulus(1, 32'h100, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0000_0013);
        idle($urandom);

        $display("[TB] directed: DM priority, then IF in the response cycle");
        applyStimulus(1, 32'h104, 1, 0, 32'h8000, 32'h0, 2'b10, 0, 32'hA5A5_0001);
        applyStimulus(1, 32'h104, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0000_0093);
        idle($urandom);

        $display("[TB] directed: store acknowledge");
        applyStimulus(0, 32'h0, 1, 1, 32'h8004, 32'hDEAD_BEEF, 2'b10, 0, 32'h5555_AAAA);
        idle($urandom);
        idle($urandom);

        $display("[TB] directed: alternating IF/DM");
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                applyStimulus(1, 32'h200 + 32'(4 * k), 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h1000 + 32'(k));
            else
                applyStimulus(0, 32'h0, 1, 0, 32'h9000 + 32'(4 * k), 32'h0, 2'b01, 1, 32'h1000 + 32'(k));
        end
        idle($urandom);

        $display("[TB] directed: sustained DM with pending fetch");
        for (int k = 0; k < 7; k++)
            applyStimulus(1, 32'h300, 1, 0, 32'hA000 + 32'(4 * k), 32'h0, 2'b10, 0, $urandom);
        idle($urandom);
        idle($urandom);

        $display("[TB] directed: reset with a fetch in flight");
        applyStimulus(1, 32'h400, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'hBAD0_BAD0);
        #1 RESET = 1'b1;
        starve = 0;
        idle($urandom);
        #1 RESET = 1'b0;
        idle($urandom);
        applyStimulus(1, 32'h404, 0, 0, 32'h0, 32'h0, 2'b00, 0, 32'h0000_0073);
        idle($urandom);

        $display("[TB] random traffic");
        rif = 0; rdm = 0; rwe = 0; rsg = 0;
        ria = 0; rda = 0; rwd = 0; rsz = 0;
        for (int i = 0; i < 400; i++) begin
            if (!rif) begin
                rif = ($urandom_range(0, 3) != 0);
                ria = $urandom & 32'hFFFF_FFFC;
            end
            if (!rdm) begin
                rdm = ($urandom_range(0, 2) == 0);
                rwe = $urandom_range(0, 1) == 1;
                rda = $urandom;
                rwd = $urandom;
                rsz = 2'($urandom_range(0, 2));
                rsg = $urandom_range(0, 1) == 1;
            end
            applyStimulus(rif, ria, rdm, rwe, rda, rwd, rsz, rsg, $urandom);
            if (last_if_gnt) rif = 0;
            if (last_dm_gnt) rdm = 0;
        end
        idle($urandom);
        idle($urandom);
        @(negedge CLK);
        #1;
        compare("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/otter_mem_arbiter.md
Name: otter_mem_arbiter

Overview:
- Arbitrates the single shared OTTER memory port between two requesters: pipeline instruction fetch (IF) and the MEM-stage data access (DM).
- Sits between the pipeline stages and OTTER_mem_byte.
- Issues at most one access per cycle and tracks which requester owns the in-flight read.
- Routes the synchronous 1-cycle read data back to the owner and drives the fetch stall to the hazard logic.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is forced to win. Used only with ARB_FAIRNESS_EN; legal range 1..15.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- IF_REQ  in  1  fetch request; held with IF_ADDR stable until IF_GNT.
- IF_ADDR  in  ADDR_W  fetch address.
- IF_GNT  out  1  fetch issued to memory this cycle (combinational).
- IF_VALID  out  1  IF_DATA valid (registered pulse).
- IF_DATA  out  DATA_W  fetched word; holds last value when IF_VALID=0.
- DM_REQ  in  1  data request; held with attributes stable until DM_GNT.
- DM_WE  in  1  1 = store, 0 = load.
- DM_ADDR  in  ADDR_W  data address.
- DM_WDATA  in  DATA_W  store data.
- DM_SIZE  in  2  access size (byte/half/word).
- DM_SIGN  in  1  load sign control.
- DM_GNT  out  1  data access issued this cycle (combinational).
- DM_VALID  out  1  load data valid / store acknowledge (registered pulse).
- DM_RDATA  out  DATA_W  load result; holds last value when DM_VALID=0.
- MEM_RD  out  1  memory read enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_SIZE  out  2  memory access size.
- MEM_SIGN  out  1  memory sign control.
- MEM_RDATA  in  DATA_W  memory read data, valid the cycle after MEM_RD.
- STALL_IF  out  1  IF_REQ & ~IF_GNT; hazard unit holds PC and IF/DE register.

Behaviour:
- Arbitration is combinational each cycle.
  - DM_REQ=1 → DM granted (older instruction, strict priority).
  - Otherwise IF_REQ=1 → IF granted.
  - IF_GNT and DM_GNT are never both 1.
- Issue mux:
  - DM grant: MEM_ADDR/WDATA/SIZE/SIGN from DM; MEM_WE=DM_WE; MEM_RD=~DM_WE.
  - IF grant: MEM_ADDR=IF_ADDR; MEM_RD=1; MEM_WE=0; MEM_SIZE=2'b10 (word); MEM_SIGN=0.
  - No grant: MEM_RD=MEM_WE=0; address/data outputs driven 0.
- Response-owner register rsp_q ∈ {RSP_NONE, RSP_IF, RSP_DM}, loaded every edge:
  - IF grant → RSP_IF.
  - DM grant (load or store) → RSP_DM.
  - Otherwise → RSP_NONE.
- Response routing, latency exactly 1 cycle from grant:
  - IF_VALID = (rsp_q==RSP_IF); DM_VALID = (rsp_q==RSP_DM).
  - IF_DATA / DM_RDATA are registered captures of MEM_RDATA, taken on the edge after the owner's VALID cycle. Each port's capture register updates only for its own owner, so the other port's value is preserved.
  - To meet the same-cycle data requirement, IF_DATA/DM_RDATA drive MEM_RDATA combinationally while their VALID=1, and the held register otherwise.
  - Store acknowledge: DM_VALID pulses; DM_RDATA content is don't-care and is not updated.
- Back-to-back traffic: a new grant is allowed every cycle regardless of rsp_q (memory is fully pipelined).
  - Sustained DM_REQ starves IF indefinitely when ARB_FAIRNESS_EN is off.
- STALL_IF = IF_REQ & ~IF_GNT, purely combinational.
- Reset (asynchronous, any time):
  - rsp_q=RSP_NONE; IF_VALID=DM_VALID=0; IF_DATA=DM_RDATA=0; starvation counter=0.
  - A read in flight at reset is discarded; no VALID follows reset deassertion.
  - Grants and MEM_* follow requests combinationally, but registered state stays reset while RESET=1.

Optional Feature:
- Macro ARB_FAIRNESS_EN: adds a 4-bit starvation counter.
  - Increments on every cycle with IF_REQ & ~IF_GNT.
  - Clears to 0 on IF grant or when IF_REQ=0.
  - When counter == STARVE_LIMIT and IF_REQ=1, IF wins over DM that cycle: DM_GNT=0 and DM stalls. The counter then clears.
- Without the macro: strict DM priority, no counter, no extra flops.

Test Plan:
- IF_REQ=1, IF_ADDR=0x100, DM_REQ=0, MEM_RDATA=0x00000013 next cycle → IF_GNT=1, MEM_RD=1, MEM_ADDR=0x100; next cycle IF_VALID=1, IF_DATA=0x13, STALL_IF=0.
- IF_REQ=1 and DM_REQ=1 (load 0x8000, size 2) same cycle → DM_GNT=1, IF_GNT=0, STALL_IF=1, MEM_ADDR=0x8000. Next cycle DM_VALID=1, DM_RDATA=MEM_RDATA; IF granted that same cycle if DM_REQ drops.
- DM store 0xDEADBEEF to 0x8004, size 2 → MEM_WE=1, MEM_RD=0, MEM_WDATA=0xDEADBEEF; next cycle DM_VALID=1, IF_VALID=0, DM_RDATA unchanged from its prior value.
- Alternating IF/DM grants over 6 cycles with distinct MEM_RDATA → each VALID pulse lands exactly 1 cycle after its grant. Data goes to the correct port only; the other port's held data is unchanged.
- With ARB_FAIRNESS_EN, STARVE_LIMIT=4, DM_REQ and IF_REQ held high → DM granted 4 cycles, IF granted on cycle 5, DM_GNT=0 that cycle, counter back to 0. Without the macro, IF_GNT stays 0 throughout.
- Assert RESET one cycle after an IF grant → IF_VALID stays 0; after deassertion rsp_q=RSP_NONE and IF_DATA=0; next request is served normally.
